wb_text_ram_ctrl: RTL and testbench
===================================

WB_TEXT_RAM_CTRL -- requirements
Module: wb_text_ram_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning text RAM address width (4096 cells).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning posted-write FIFO entries (power of two, 2..16).
REQ-003 SHALL have port clk  in  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have ports wb_adr_i in 8, wb_dat_i in 8, wb_dat_o out 8, wb_cyc_i in 1, wb_stb_i in 1, wb_we_i in 1, wb_ack_o out 1: Wishbone slave decoding wb_adr_i[3:0], base 0x20.
REQ-006 SHALL have ports vid_req in 1, vid_addr in ADDR_W, vid_valid out 1, vid_char out 8, vid_attr out 8: video fetch port.
REQ-007 SHALL have ports ram_addr out ADDR_W, ram_we out 1, ram_wchar out 8, ram_wattr out 8, ram_rchar in 8, ram_rattr in 8: single-port text RAM with 1-cycle read latency.

Function
REQ-008 SHALL map registers: 0x0 ADDR_LO, 0x1 ADDR_HI (bits[3:0]), 0x2 CHAR, 0x3 ATTR (shadow), 0x4 CTRL (bit0 autoinc), 0x5 STATUS ({busy, fifo_full, fifo_empty, 1'b0, level[3:0]}), 0x8 VERSION = 0x01; other offsets read 0x00, writes ignored.
REQ-009 SHALL pulse wb_ack_o for exactly one cycle per access and never acknowledge on the cycle after an ack.
REQ-010 SHALL ack register accesses other than CHAR one cycle after wb_cyc_i&wb_stb_i is sampled.
REQ-011 SHALL on a CHAR write push {addr, wb_dat_i, attr_shadow} into the FIFO and ack next cycle; when the FIFO is full, ack is withheld until an entry drains.
REQ-012 SHALL give the video port absolute priority: vid_req high drives ram_addr=vid_addr, ram_we=0 that cycle.
REQ-013 SHALL assert vid_valid exactly one cycle after vid_req with vid_char/vid_attr equal to ram_rchar/ram_rattr.
REQ-014 SHALL drain one FIFO entry (ram_we=1) in each cycle vid_req is low and no CPU read is issued.
REQ-015 SHALL serve a CHAR read with FSM IDLE -> DRAIN (until FIFO empty) -> ISSUE (waits for vid_req low; drives read) -> DATA (captures rchar into wb_dat_o and rattr into attr_shadow, acks) -> IDLE.
REQ-016 SHALL, when autoinc=1, increment addr by 1 after each acked CHAR access, wrapping 0xFFF -> 0x000.
REQ-017 SHALL treat a CHAR read ordered after posted writes to the same address as returning the newest written data.
REQ-018 SHALL abandon an in-flight read without ack when wb_cyc_i drops, returning to IDLE; FIFO contents are retained.
REQ-019 SHALL on simultaneous FIFO push and pop keep the level unchanged.

Reset
REQ-020 SHALL while rst_n low force wb_ack_o=0, wb_dat_o=0x00, vid_valid=0, vid_char=vid_attr=0x00, ram_we=0, ram_addr=0, addr=0, attr_shadow=0x07, autoinc=1, FIFO empty, FSM IDLE.
REQ-021 SHALL discard pending FIFO writes on reset mid-operation; no ram_we pulse after rst_n falls.

Configuration
REQ-022 SHALL, with TEXT_RAM_STATS_EN defined, implement a 16-bit saturating counter of cycles a CPU access waits on video priority or FIFO-full, read at 0x6 (lo)/0x7 (hi), cleared by any write to 0x6.
REQ-023 SHALL, without TEXT_RAM_STATS_EN, read 0x00 at 0x6/0x7 and contain no counter logic.

Structure
REQ-024 SHALL place register offsets, FSM state encoding, VERSION and the reset attribute 0x07 in shared package text_ram_pkg.
REQ-025 SHALL implement the posted-write buffer as sub-module text_wr_fifo (sync FIFO, level/full/empty outputs).

Verification
REQ-026 SHALL cover: ADDR=0x123, autoinc=1, ATTR=0x1E, CHAR writes 0x41,0x42 -> RAM cells 0x123/0x124 = {0x41,0x1E},{0x42,0x1E}; ADDR reads back 0x125.
REQ-027 SHALL cover: vid_req held high 10 cycles while 5 CHAR writes posted -> 4 acked, 5th stalls, no ram_we until vid_req low, then drains in order.
REQ-028 SHALL cover: write 0x55 to 0x010 then immediately read 0x010 -> wb_dat_o=0x55, ATTR shadow updated from RAM.
REQ-029 SHALL cover: ADDR=0xFFF, autoinc, two CHAR writes -> cells 0xFFF and 0x000 written.
REQ-030 SHALL cover: rst_n low mid-drain with 3 entries queued -> no further ram_we; STATUS reads 0x20 after release.
REQ-031 SHALL cover (TEXT_RAM_STATS_EN): CHAR read issued during 6-cycle vid_req burst -> counter at 0x6 reads >=6; write 0x6 -> reads 0x00.

Source files
------------

// File: rtl/text_ram_pkg.sv
// Shared definitions for the Wishbone text RAM controller: register map,
// read FSM encoding, VERSION value and reset attribute.
package text_ram_pkg;

    // Wishbone window 0x20..0x2F: upper nibble of the bus address
    localparam logic [3:0] WB_BASE_HI   = 4'h2;

    // Register offsets within the window
    localparam logic [3:0] REG_ADDR_LO  = 4'h0;
    localparam logic [3:0] REG_ADDR_HI  = 4'h1;
    localparam logic [3:0] REG_CHAR     = 4'h2;
    localparam logic [3:0] REG_ATTR     = 4'h3;
    localparam logic [3:0] REG_CTRL     = 4'h4;
    localparam logic [3:0] REG_STATUS   = 4'h5;
    localparam logic [3:0] REG_STATS_LO = 4'h6;
    localparam logic [3:0] REG_STATS_HI = 4'h7;
    localparam logic [3:0] REG_VERSION  = 4'h8;

    localparam logic [7:0] VERSION_VAL  = 8'h01;
    localparam logic [7:0] ATTR_RESET   = 8'h07;

    // CHAR read sequencing
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_ISSUE = 2'd2,
        ST_DATA  = 2'd3
    } rd_state_t;

endpackage

// File: rtl/text_wr_fifo.sv
// Posted-write buffer: small synchronous FIFO with a combinational head
// so the oldest entry can be written to the text RAM in the same cycle.
module text_wr_fifo #(
    parameter int WIDTH = 28,
    parameter int DEPTH = 4,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [PW:0]      level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [PW:0]      level_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (level_reg == (PW+1)'(DEPTH));
    assign empty   = (level_reg == '0);
    assign level   = level_reg;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr_reg];

    // Storage: no reset needed, entries are only visible through level
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= wdata;
    end

    // Pointers and occupancy; push+pop together leaves the level unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            case ({do_push, do_pop})
                2'b10:   level_reg <= level_reg + (PW+1)'(1);
                2'b01:   level_reg <= level_reg - (PW+1)'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

endmodule

// File: rtl/wb_text_ram_ctrl.sv
// Wishbone text RAM controller: CPU register window at 0x20, posted CHAR
// writes through a FIFO, CHAR reads via a drain/issue/data FSM, and a video
// fetch port that always wins the single RAM port.
// Optional: define TEXT_RAM_STATS_EN for a 16-bit stall counter at 0x6/0x7.
module wb_text_ram_ctrl
    import text_ram_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        wb_adr_i,
    input  logic [7:0]        wb_dat_i,
    output logic [7:0]        wb_dat_o,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    output logic              wb_ack_o,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_valid,
    output logic [7:0]        vid_char,
    output logic [7:0]        vid_attr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_wchar,
    output logic [7:0]        ram_wattr,
    input  logic [7:0]        ram_rchar,
    input  logic [7:0]        ram_rattr
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int EW = ADDR_W + 16;

    rd_state_t         state_reg, state_next;
    logic              ack_reg, ack_next;
    logic [7:0]        dat_o_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [7:0]        attr_reg;
    logic              autoinc_reg;
    logic              vid_valid_reg;

    logic [EW-1:0]     fifo_rdata;
    logic              fifo_full, fifo_empty;
    logic [LW-1:0]     fifo_level;

    logic [3:0]        off;
    logic              hit, req, char_sel, idle;
    logic              push_ok, reg_wr, reg_rd, read_issue, read_done, pop;
    logic [7:0]        rd_mux;
    logic [3:0]        addr_hi4;

    assign off      = wb_adr_i[3:0];
    assign hit      = (wb_adr_i[7:4] == WB_BASE_HI);
    // Gating with the current ack keeps acks from ever landing back to back
    assign req      = wb_cyc_i && wb_stb_i && !ack_reg;
    assign char_sel = hit && (off == REG_CHAR);
    assign idle     = (state_reg == ST_IDLE);
    assign push_ok  = idle && req && char_sel && wb_we_i && !fifo_full;
    assign reg_wr   = idle && req && wb_we_i && hit && (off != REG_CHAR);
    assign reg_rd   = idle && req && !wb_we_i && !char_sel;
    assign read_issue = (state_reg == ST_ISSUE) && wb_cyc_i && !vid_req;
    assign read_done  = (state_reg == ST_DATA) && wb_cyc_i;
    // Drain whenever the port is free of video and of a CPU read
    assign pop      = !vid_req && !read_issue && !fifo_empty;
    assign addr_hi4 = 4'(addr_reg >> 8);

    text_wr_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_ok),
        .wdata ({addr_reg, wb_dat_i, attr_reg}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

`ifdef TEXT_RAM_STATS_EN
    logic [15:0] stall_cnt_reg;
    logic        stall;

    // A CPU access is stalled by video priority or a full FIFO
    assign stall = wb_cyc_i && wb_stb_i &&
                   ((idle && req && char_sel && wb_we_i && fifo_full) ||
                    (idle && req && char_sel && !wb_we_i && vid_req) ||
                    ((state_reg == ST_DRAIN || state_reg == ST_ISSUE) && vid_req));

    // Saturating stall counter, cleared by a write to STATS_LO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt_reg <= '0;
        else if (reg_wr && off == REG_STATS_LO)
            stall_cnt_reg <= '0;
        else if (stall && stall_cnt_reg != 16'hFFFF)
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
`endif

    // Register read multiplexer
    always_comb begin
        rd_mux = 8'h00;
        if (hit) begin
            case (off)
                REG_ADDR_LO:  rd_mux = addr_reg[7:0];
                REG_ADDR_HI:  rd_mux = {4'h0, addr_hi4};
                REG_ATTR:     rd_mux = attr_reg;
                REG_CTRL:     rd_mux = {7'b0, autoinc_reg};
                REG_STATUS:   rd_mux = {(state_reg != ST_IDLE) || !fifo_empty,
                                        fifo_full, fifo_empty, 1'b0, 4'(fifo_level)};
`ifdef TEXT_RAM_STATS_EN
                REG_STATS_LO: rd_mux = stall_cnt_reg[7:0];
                REG_STATS_HI: rd_mux = stall_cnt_reg[15:8];
`endif
                REG_VERSION:  rd_mux = VERSION_VAL;
                default:      rd_mux = 8'h00;
            endcase
        end
    end

    // Read FSM and ack generation
    always_comb begin
        state_next = state_reg;
        ack_next   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (req) begin
                    if (char_sel && !wb_we_i)
                        state_next = ST_DRAIN;
                    else if (!char_sel || !fifo_full)
                        ack_next = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (!wb_cyc_i)       state_next = ST_IDLE;
                else if (fifo_empty) state_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (!wb_cyc_i)     state_next = ST_IDLE;
                else if (!vid_req) state_next = ST_DATA;
            end
            ST_DATA: begin
                state_next = ST_IDLE;
                ack_next   = wb_cyc_i;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // RAM port arbitration: video, then CPU read, then FIFO drain
    always_comb begin
        ram_addr = '0;
        if (!rst_n)
            ram_addr = '0;
        else if (vid_req)
            ram_addr = vid_addr;
        else if (read_issue)
            ram_addr = addr_reg;
        else if (!fifo_empty)
            ram_addr = fifo_rdata[EW-1:16];
    end

    assign ram_we    = pop;
    assign ram_wchar = fifo_rdata[15:8];
    assign ram_wattr = fifo_rdata[7:0];

    assign wb_ack_o  = ack_reg;
    assign wb_dat_o  = dat_o_reg;
    assign vid_valid = vid_valid_reg;
    assign vid_char  = vid_valid_reg ? ram_rchar : 8'h00;
    assign vid_attr  = vid_valid_reg ? ram_rattr : 8'h00;

    // Control registers, read data, address pointer and attribute shadow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            ack_reg       <= 1'b0;
            dat_o_reg     <= 8'h00;
            addr_reg      <= '0;
            attr_reg      <= ATTR_RESET;
            autoinc_reg   <= 1'b1;
            vid_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ack_reg       <= ack_next;
            vid_valid_reg <= vid_req;
            if (reg_wr) begin
                case (off)
                    REG_ADDR_LO: addr_reg    <= ADDR_W'({addr_hi4, wb_dat_i});
                    REG_ADDR_HI: addr_reg    <= ADDR_W'({wb_dat_i[3:0], addr_reg[7:0]});
                    REG_ATTR:    attr_reg    <= wb_dat_i;
                    REG_CTRL:    autoinc_reg <= wb_dat_i[0];
                    default:     ;
                endcase
            end
            if (reg_rd)
                dat_o_reg <= rd_mux;
            if (read_done) begin
                dat_o_reg <= ram_rchar;
                attr_reg  <= ram_rattr;
            end
            if ((push_ok || read_done) && autoinc_reg)
                addr_reg <= addr_reg + ADDR_W'(1);
        end
    end

endmodule

// File: tb/tb_wb_text_ram_ctrl.sv
// Directed bench for wb_text_ram_ctrl with a behavioural 1-cycle text RAM.
module tb_wb_text_ram_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  wb_adr_i = 8'h00, wb_dat_i = 8'h00, wb_dat_o;
    logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0, wb_ack_o;
    logic        vid_req = 1'b0;
    logic [11:0] vid_addr = 12'h000;
    logic        vid_valid;
    logic [7:0]  vid_char, vid_attr;
    logic [11:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wchar, ram_wattr, ram_rchar, ram_rattr;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    wb_text_ram_ctrl #(.ADDR_W(12), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_ack_o(wb_ack_o),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_valid(vid_valid),
        .vid_char(vid_char), .vid_attr(vid_attr),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wchar(ram_wchar), .ram_wattr(ram_wattr),
        .ram_rchar(ram_rchar), .ram_rattr(ram_rattr)
    );

    // Text RAM model plus write log and counters
    logic [15:0] mem [4096];
    logic [15:0] rd_q;
    logic [31:0] wlog [$];
    int we_cnt = 0;
    int prio_viol = 0;
    assign ram_rchar = rd_q[15:8];
    assign ram_rattr = rd_q[7:0];

    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= {ram_wchar, ram_wattr};
            we_cnt <= we_cnt + 1;
            wlog.push_back({4'h0, ram_addr, ram_wchar, ram_wattr});
            if (vid_req) prio_viol <= prio_viol + 1;
        end
        rd_q <= mem[ram_addr];
    end

    // Ack monitor
    logic ack_prev = 1'b0;
    int ack_total = 0;
    int ack_viol = 0;
    always @(negedge clk) begin
        if (wb_ack_o) ack_total <= ack_total + 1;
        if (wb_ack_o && ack_prev) ack_viol <= ack_viol + 1;
        ack_prev <= wb_ack_o;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wb_start(input logic [7:0] adr, input logic [7:0] dat, input logic we);
        @(negedge clk);
        wb_adr_i = adr; wb_dat_i = dat; wb_we_i = we;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    endtask

    // Waits up to max cycles for ack; releases the bus only if acked
    task automatic wb_wait(input int max, output logic ok, output logic [7:0] d);
        int n;
        ok = 1'b0; d = 8'h00; n = 0;
        while (!ok && n < max) begin
            @(posedge clk); #1;
            n++;
            if (wb_ack_o) begin ok = 1'b1; d = wb_dat_o; end
        end
        if (ok) begin wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; end
    endtask

    task automatic wr(input logic [7:0] adr, input logic [7:0] dat);
        logic ok; logic [7:0] d;
        wb_start(adr, dat, 1'b1);
        wb_wait(20, ok, d);
        $display("wb wr adr=0x%02h dat=0x%02h ack=%0d", adr, dat, ok);
        check($sformatf("wr_ack_%02h", adr), 32'(ok), 32'd1);
        if (!ok) begin wb_cyc_i = 1'b0; wb_stb_i = 1'b0; end
    endtask

    task automatic rd(input logic [7:0] adr, output logic [7:0] d);
        logic ok;
        wb_start(adr, 8'h00, 1'b0);
        wb_wait(20, ok, d);
        $display("wb rd adr=0x%02h dat=0x%02h ack=%0d", adr, d, ok);
        check($sformatf("rd_ack_%02h", adr), 32'(ok), 32'd1);
        if (!ok) begin wb_cyc_i = 1'b0; wb_stb_i = 1'b0; end
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] adr, input logic [7:0] exp);
        logic [7:0] d;
        rd(adr, d);
        check(tag, 32'(d), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ok;
        logic [7:0] d;
        int snap, ack_snap, lsz;

        // Reset with video active: outputs must still be quiet
        rst_n = 1'b0; vid_req = 1'b1; vid_addr = 12'h555;
        repeat (3) @(negedge clk);
        check("rst_ack", 32'(wb_ack_o), 0);
        check("rst_dat", 32'(wb_dat_o), 0);
        check("rst_vvalid", 32'(vid_valid), 0);
        check("rst_vchar", 32'(vid_char), 0);
        check("rst_ram_we", 32'(ram_we), 0);
        check("rst_ram_addr", 32'(ram_addr), 0);
        vid_req = 1'b0;
        rst_n = 1'b1;
        rd_chk("status_rst", 8'h25, 8'h20);
        rd_chk("attr_rst", 8'h23, 8'h07);
        rd_chk("ctrl_rst", 8'h24, 8'h01);
        rd_chk("version", 8'h28, 8'h01);
        rd_chk("unmapped_f", 8'h2F, 8'h00);

        // Autoinc CHAR writes with a set attribute
        wr(8'h20, 8'h23); wr(8'h21, 8'h01); wr(8'h23, 8'h1E);
        wr(8'h22, 8'h41); wr(8'h22, 8'h42);
        repeat (5) @(negedge clk);
        check("cell_123", 32'(mem[12'h123]), 32'h411E);
        check("cell_124", 32'(mem[12'h124]), 32'h421E);
        rd_chk("addr_lo_125", 8'h20, 8'h25);
        rd_chk("addr_hi_125", 8'h21, 8'h01);

        // Video priority: FIFO fills, fifth write stalls, no RAM writes
        wr(8'h20, 8'h00); wr(8'h21, 8'h02);
        @(negedge clk);
        vid_req = 1'b1; vid_addr = 12'h123;
        wlog.delete();
        snap = we_cnt;
        for (int i = 0; i < 4; i++) wr(8'h22, 8'(8'h60 + i));
        wb_start(8'h22, 8'h64, 1'b1);
        wb_wait(4, ok, d);
        check("fifth_stalls", 32'(ok), 0);
        check("vid_valid_on", 32'(vid_valid), 1);
        check("vid_char", 32'(vid_char), 32'h41);
        check("vid_attr", 32'(vid_attr), 32'h1E);
        check("no_we_during_vid", 32'(we_cnt - snap), 0);
        @(negedge clk);
        vid_req = 1'b0;
        wb_wait(10, ok, d);
        $display("wb wr adr=0x22 dat=0x64 ack=%0d (after stall)", ok);
        check("fifth_acked", 32'(ok), 1);
        repeat (8) @(negedge clk);
        check("vid_valid_off", 32'(vid_valid), 0);
        lsz = wlog.size();
        check("drain_count", 32'(lsz), 5);
        for (int i = 0; i < 5 && i < lsz; i++)
            check($sformatf("drain_%0d", i), wlog[i],
                  ((32'h200 + 32'(i)) << 16) | ((32'h60 + 32'(i)) << 8) | 32'h1E);

        // Read-after-posted-write to the same cell returns newest data
        wr(8'h24, 8'h00);
        wr(8'h20, 8'h10); wr(8'h21, 8'h00);
        @(negedge clk);
        vid_req = 1'b1;
        wr(8'h23, 8'h33); wr(8'h22, 8'h54);
        wr(8'h23, 8'h44); wr(8'h22, 8'h55);
        wr(8'h23, 8'h66);
        wb_start(8'h22, 8'h00, 1'b0);
        wb_wait(3, ok, d);
        check("raw_held", 32'(ok), 0);
        @(negedge clk);
        vid_req = 1'b0;
        wb_wait(20, ok, d);
        $display("wb rd adr=0x22 dat=0x%02h ack=%0d", d, ok);
        check("raw_ack", 32'(ok), 1);
        check("raw_data", 32'(d), 32'h55);
        rd_chk("raw_attr", 8'h23, 8'h44);
        wr(8'h24, 8'h01);

        // Abandoned read: no ack, address unchanged, FSM back to idle
        @(negedge clk);
        vid_req = 1'b1;
        wb_start(8'h22, 8'h00, 1'b0);
        wb_wait(3, ok, d);
        check("abort_pending", 32'(ok), 0);
        @(negedge clk);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        ack_snap = ack_total;
        repeat (4) @(negedge clk);
        vid_req = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_no_ack", 32'(ack_total - ack_snap), 0);
        rd_chk("abort_addr", 8'h20, 8'h10);
        rd_chk("abort_status", 8'h25, 8'h20);

        // Address wrap 0xFFF -> 0x000
        wr(8'h20, 8'hFF); wr(8'h21, 8'h0F); wr(8'h23, 8'h70);
        wr(8'h22, 8'h11); wr(8'h22, 8'h22);
        repeat (5) @(negedge clk);
        check("cell_fff", 32'(mem[12'hFFF]), 32'h1170);
        check("cell_000", 32'(mem[12'h000]), 32'h2270);
        rd_chk("wrap_lo", 8'h20, 8'h01);
        rd_chk("wrap_hi", 8'h21, 8'h00);

        // CHAR read issued at the start of a 6-cycle video burst
        wr(8'h20, 8'h23); wr(8'h21, 8'h01);
        wr(8'h26, 8'h00);
        @(negedge clk);
        vid_req = 1'b1;
        wb_adr_i = 8'h22; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        repeat (6) @(negedge clk);
        vid_req = 1'b0;
        wb_wait(20, ok, d);
        $display("wb rd adr=0x22 dat=0x%02h ack=%0d (video burst)", d, ok);
        check("burst_ack", 32'(ok), 1);
        check("burst_data", 32'(d), 32'h41);
        rd_chk("burst_attr", 8'h23, 8'h1E);
`ifdef TEXT_RAM_STATS_EN
        rd(8'h26, d);
        check("stats_ge6", 32'(d >= 8'd6), 1);
        wr(8'h26, 8'h00);
        rd_chk("stats_clr_lo", 8'h26, 8'h00);
        rd_chk("stats_clr_hi", 8'h27, 8'h00);
`else
        rd_chk("stats_lo_off", 8'h26, 8'h00);
        rd_chk("stats_hi_off", 8'h27, 8'h00);
`endif

        // Reset in the middle of a drain discards the remaining entries
        wr(8'h20, 8'h00); wr(8'h21, 8'h03);
        @(negedge clk);
        vid_req = 1'b1;
        wr(8'h22, 8'h71); wr(8'h22, 8'h72); wr(8'h22, 8'h73);
        @(negedge clk);
        vid_req = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        snap = we_cnt;
        lsz = wlog.size();
        check("mid_rst_ram_we", 32'(ram_we), 0);
        check("mid_rst_one_written", 32'(mem[12'h300]), 32'h711E);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("no_we_after_rst", 32'(we_cnt - snap), 0);
        check("no_log_after_rst", 32'(wlog.size() - lsz), 0);
        rd_chk("status_after_rst", 8'h25, 8'h20);
        rd_chk("attr_after_rst", 8'h23, 8'h07);
        rd_chk("addr_after_rst", 8'h20, 8'h00);

        repeat (2) @(negedge clk);
        check("vid_prio_we", 32'(prio_viol), 0);
        check("ack_back2back", 32'(ack_viol), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
